// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-requester RAM port arbiter: requester select encoding
// used by the round-robin pointers and the read-return tag.
package ram_port_arbiter_pkg;

    typedef enum logic {
        SEL_M0 = 1'b0,
        SEL_M1 = 1'b1
    } sel_e;

    // Two-bit one-hot grant to the winning requester (no grant decodes as m0).
    function automatic sel_e gnt_to_sel(input logic [1:0] gnt);
        return gnt[1] ? SEL_M1 : SEL_M0;
    endfunction

endpackage

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: one write port, one read port, registered read.
// A same-address read and write in one cycle returns the old content.
module ram_dual_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational; after any grant the
// pointer moves to the requester that did not win, so a held request waits at most one cycle.
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    sel_e r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (!reset) begin
            if (i_req == 2'b11) begin
                o_gnt = (r_ptr == SEL_M0) ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= SEL_M0;
        end else if (o_gnt[0]) begin
            r_ptr <= SEL_M1;
        end else if (o_gnt[1]) begin
            r_ptr <= SEL_M0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM between two requesters; read and write ports
// are arbitrated independently and read data is steered back by a 1-bit tag.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int FORWARD    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_rd_req,
    input  logic [ADDR_WIDTH-1:0] m0_rd_addr,
    output logic                  m0_rd_gnt,
    output logic                  m0_rd_valid,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    input  logic                  m0_wr_req,
    input  logic [ADDR_WIDTH-1:0] m0_wr_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    output logic                  m0_wr_gnt,
    input  logic                  m1_rd_req,
    input  logic [ADDR_WIDTH-1:0] m1_rd_addr,
    output logic                  m1_rd_gnt,
    output logic                  m1_rd_valid,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    input  logic                  m1_wr_req,
    input  logic [ADDR_WIDTH-1:0] m1_wr_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    output logic                  m1_wr_gnt
);

    logic [1:0]            w_rd_gnt;
    logic [1:0]            w_wr_gnt;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_ram_q;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_v0;
    logic                  w_v1;

    logic                  r_rd_valid;
    sel_e                  r_rd_tag;
    logic                  r_fwd_hit;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic [DATA_WIDTH-1:0] r_hold0;
    logic [DATA_WIDTH-1:0] r_hold1;

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .i_req ({m1_rd_req, m0_rd_req}),
        .o_gnt (w_rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .i_req ({m1_wr_req, m0_wr_req}),
        .o_gnt (w_wr_gnt)
    );

    assign m0_rd_gnt = w_rd_gnt[0];
    assign m1_rd_gnt = w_rd_gnt[1];
    assign m0_wr_gnt = w_wr_gnt[0];
    assign m1_wr_gnt = w_wr_gnt[1];

    assign w_rd_addr = w_rd_gnt[1] ? m1_rd_addr : m0_rd_addr;
    assign w_wr_addr = w_wr_gnt[1] ? m1_wr_addr : m0_wr_addr;
    assign w_wr_data = w_wr_gnt[1] ? m1_wr_data : m0_wr_data;
    assign w_we      = |w_wr_gnt;

    ram_dual_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    // A read that was in flight when reset rose must not surface during reset.
    assign w_v0    = r_rd_valid && !reset && (r_rd_tag == SEL_M0);
    assign w_v1    = r_rd_valid && !reset && (r_rd_tag == SEL_M1);
    assign w_rdata = r_fwd_hit ? r_fwd_data : w_ram_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_tag   <= SEL_M0;
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
            r_hold0    <= '0;
            r_hold1    <= '0;
        end else begin
            r_rd_valid <= |w_rd_gnt;
            r_rd_tag   <= gnt_to_sel(w_rd_gnt);
            r_fwd_hit  <= (FORWARD != 0) && (|w_rd_gnt) && w_we && (w_rd_addr == w_wr_addr);
            r_fwd_data <= w_wr_data;
            if (w_v0) begin
                r_hold0 <= w_rdata;
            end
            if (w_v1) begin
                r_hold1 <= w_rdata;
            end
        end
    end

    assign m0_rd_valid = w_v0;
    assign m1_rd_valid = w_v1;
    assign m0_rd_data  = w_v0 ? w_rdata : r_hold0;
    assign m1_rd_data  = w_v1 ? w_rdata : r_hold1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: stimulus pushes expected read data per
// requester; a negedge monitor pops and compares whenever a read valid appears.
module tb_ram_port_arbiter;

    localparam int DW  = 8;
    localparam int AW  = 6;
    localparam int FWD = 1;

    logic          clk;
    logic          reset;
    logic          m0_rd_req, m1_rd_req;
    logic [AW-1:0] m0_rd_addr, m1_rd_addr;
    logic          m0_rd_gnt, m1_rd_gnt;
    logic          m0_rd_valid, m1_rd_valid;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          m0_wr_req, m1_wr_req;
    logic [AW-1:0] m0_wr_addr, m1_wr_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_wr_gnt, m1_wr_gnt;

    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    int            n_pass;
    int            n_total;

    ram_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FORWARD    (FWD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_rd_req   (m0_rd_req),
        .m0_rd_addr  (m0_rd_addr),
        .m0_rd_gnt   (m0_rd_gnt),
        .m0_rd_valid (m0_rd_valid),
        .m0_rd_data  (m0_rd_data),
        .m0_wr_req   (m0_wr_req),
        .m0_wr_addr  (m0_wr_addr),
        .m0_wr_data  (m0_wr_data),
        .m0_wr_gnt   (m0_wr_gnt),
        .m1_rd_req   (m1_rd_req),
        .m1_rd_addr  (m1_rd_addr),
        .m1_rd_gnt   (m1_rd_gnt),
        .m1_rd_valid (m1_rd_valid),
        .m1_rd_data  (m1_rd_data),
        .m1_wr_req   (m1_wr_req),
        .m1_wr_addr  (m1_wr_addr),
        .m1_wr_data  (m1_wr_data),
        .m1_wr_gnt   (m1_wr_gnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks: raise a request, wait (bounded) for the grant, then drop it.
    task automatic do_write(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic got;
        got = 1'b0;
        if (m == 0) begin
            m0_wr_req = 1'b1; m0_wr_addr = addr; m0_wr_data = data;
        end else begin
            m1_wr_req = 1'b1; m1_wr_addr = addr; m1_wr_data = data;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_wr_gnt : m1_wr_gnt) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        chk("wr_gnt_within_bound", {31'd0, got}, 32'd1);
        if (got) next_cycle();
        m0_wr_req = 1'b0;
        m1_wr_req = 1'b0;
    endtask

    task automatic do_read(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        logic got;
        got = 1'b0;
        if (m == 0) begin
            m0_rd_req = 1'b1; m0_rd_addr = addr;
        end else begin
            m1_rd_req = 1'b1; m1_rd_addr = addr;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_rd_gnt : m1_rd_gnt) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        chk("rd_gnt_within_bound", {31'd0, got}, 32'd1);
        if (got) begin
            if (m == 0) exp0_q.push_back(exp);
            else        exp1_q.push_back(exp);
            next_cycle();
        end
        m0_rd_req = 1'b0;
        m1_rd_req = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (m0_rd_valid === 1'b1) begin
                if (exp0_q.size() > 0) chk("m0_rd_data", {24'd0, m0_rd_data}, {24'd0, exp0_q.pop_front()});
                else                   chk("m0_spurious_valid", {31'd0, m0_rd_valid}, 32'd0);
            end
            if (m1_rd_valid === 1'b1) begin
                if (exp1_q.size() > 0) chk("m1_rd_data", {24'd0, m1_rd_data}, {24'd0, exp1_q.pop_front()});
                else                   chk("m1_spurious_valid", {31'd0, m1_rd_valid}, 32'd0);
            end
        end
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        m0_rd_req = 1'b1; m0_rd_addr = '0;
        m1_rd_req = 1'b1; m1_rd_addr = '0;
        m0_wr_req = 1'b0; m0_wr_addr = '0; m0_wr_data = '0;
        m1_wr_req = 1'b0; m1_wr_addr = '0; m1_wr_data = '0;

        // Reset held 3 cycles with both reads requested
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnts", {28'd0, m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt}, 32'd0);
            chk("rst_valids", {30'd0, m0_rd_valid, m1_rd_valid}, 32'd0);
            chk("rst_data", {16'd0, m0_rd_data, m1_rd_data}, 32'd0);
        end

        // First post-reset contended cycle: m0 wins; a same-address write forwards
        next_cycle();
        reset = 1'b0;
        m0_wr_req = 1'b1; m0_wr_addr = 6'd0; m0_wr_data = 8'h5A;
        @(negedge clk);
        chk("post_rst_rd_gnt", {30'd0, m0_rd_gnt, m1_rd_gnt}, 32'b10);
        chk("post_rst_wr_gnt", {31'd0, m0_wr_gnt}, 32'd1);
        if (m0_rd_gnt) exp0_q.push_back(FWD != 0 ? 8'h5A : 8'h00);
        next_cycle();
        m0_rd_req = 1'b0; m1_rd_req = 1'b0; m0_wr_req = 1'b0;

        // Single writer then reader
        do_write(0, 6'd5, 8'hA5);
        m1_rd_req = 1'b1; m1_rd_addr = 6'd5;
        @(negedge clk);
        chk("single_m1_rd_gnt", {31'd0, m1_rd_gnt}, 32'd1);
        if (m1_rd_gnt) exp1_q.push_back(8'hA5);
        next_cycle();
        m1_rd_req = 1'b0;
        @(negedge clk);
        chk("single_valids", {30'd0, m0_rd_valid, m1_rd_valid}, 32'b01);

        // Seed data: m1 write leaves the write pointer on m0
        next_cycle();
        do_write(0, 6'd1, 8'h11);
        do_write(1, 6'd2, 8'h22);

        // Read contention: alternating grants
        m0_rd_req = 1'b1; m0_rd_addr = 6'd1;
        m1_rd_req = 1'b1; m1_rd_addr = 6'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("contend_rd_gnt", {30'd0, m0_rd_gnt, m1_rd_gnt}, (k % 2 == 0) ? 32'b10 : 32'b01);
            if (m0_rd_gnt) exp0_q.push_back(8'h11);
            if (m1_rd_gnt) exp1_q.push_back(8'h22);
            next_cycle();
        end
        m0_rd_req = 1'b0; m1_rd_req = 1'b0;

        // Write contention to address 3: m0 then m1
        m0_wr_req = 1'b1; m0_wr_addr = 6'd3; m0_wr_data = 8'h33;
        m1_wr_req = 1'b1; m1_wr_addr = 6'd3; m1_wr_data = 8'h44;
        @(negedge clk);
        chk("contend_wr_first", {30'd0, m0_wr_gnt, m1_wr_gnt}, 32'b10);
        next_cycle();
        m0_wr_req = 1'b0;
        @(negedge clk);
        chk("contend_wr_second", {30'd0, m0_wr_gnt, m1_wr_gnt}, 32'b01);
        next_cycle();
        m1_wr_req = 1'b0;
        do_read(0, 6'd3, 8'h44);

        // Collision: m0 writes 0x99 to 7 while m1 reads 7
        do_write(0, 6'd7, 8'h01);
        m0_wr_req = 1'b1; m0_wr_addr = 6'd7; m0_wr_data = 8'h99;
        m1_rd_req = 1'b1; m1_rd_addr = 6'd7;
        @(negedge clk);
        chk("collide_gnts", {30'd0, m0_wr_gnt, m1_rd_gnt}, 32'b11);
        if (m1_rd_gnt) exp1_q.push_back(FWD != 0 ? 8'h99 : 8'h01);
        next_cycle();
        m0_wr_req = 1'b0; m1_rd_req = 1'b0;
        do_read(0, 6'd7, 8'h99);

        // Reset mid-read: pointers currently favour m1 on both ports
        m1_rd_req = 1'b1; m1_rd_addr = 6'd7;
        @(negedge clk);
        chk("midrst_gnt", {31'd0, m1_rd_gnt}, 32'd1);
        next_cycle();
        reset = 1'b1;
        m1_rd_req = 1'b0;
        @(negedge clk);
        chk("midrst_valid_n1", {30'd0, m0_rd_valid, m1_rd_valid}, 32'd0);
        next_cycle();
        reset = 1'b0;
        m0_rd_req = 1'b1; m0_rd_addr = 6'd7;
        m1_rd_req = 1'b1; m1_rd_addr = 6'd5;
        m0_wr_req = 1'b1; m0_wr_addr = 6'd8; m0_wr_data = 8'h12;
        m1_wr_req = 1'b1; m1_wr_addr = 6'd9; m1_wr_data = 8'h34;
        @(negedge clk);
        chk("midrst_valid_n2", {30'd0, m0_rd_valid, m1_rd_valid}, 32'd0);
        chk("midrst_rd_ptr_m0", {30'd0, m0_rd_gnt, m1_rd_gnt}, 32'b10);
        chk("midrst_wr_ptr_m0", {30'd0, m0_wr_gnt, m1_wr_gnt}, 32'b10);
        if (m0_rd_gnt) exp0_q.push_back(8'h99);
        next_cycle();
        m0_rd_req = 1'b0; m1_rd_req = 1'b0;
        m0_wr_req = 1'b0; m1_wr_req = 1'b0;

        repeat (3) next_cycle();
        chk("exp0_q_drained", exp0_q.size(), 32'd0);
        chk("exp1_q_drained", exp1_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
